// File: rtl/lsu_ctrl.sv
// RV32I load/store unit: one request at a time, word-wide memory traffic,
// byte-lane extract/extend, read-modify-write for SB/SH, error response.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        memread,
  output logic        memwrite,
  output logic [31:0] addr,
  output logic [31:0] wr_data,
  output logic [2:0]  data_type,
  input  logic [31:0] out_data,
  input  logic        mem_rd_comp,
  input  logic        mem_wr_comp
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RESP
  } state_t;

  localparam logic [2:0] DT_WORD = 3'b010;

  state_t           r_state;
  logic             r_we;
  logic [2:0]       r_f3;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_word;
  logic [CNT_W-1:0] r_cnt;

  logic             w_req_err;
  logic             w_timeout;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_load_data;
  logic [31:0]      w_merged;

  // Request legality is judged on the live request so IDLE can route in one edge.
  always_comb begin
    w_req_err = 1'b0;
    if (req_we) begin
      if (req_funct3[2] || (req_funct3[1:0] == 2'b11))
        w_req_err = 1'b1;
    end else begin
      if ((req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111))
        w_req_err = 1'b1;
    end
    if ((req_funct3[1:0] == 2'b01) && req_addr[0])
      w_req_err = 1'b1;
    if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
      w_req_err = 1'b1;
  end

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_byte = out_data[7:0];
    case (r_addr[1:0])
      2'd0: w_byte = out_data[7:0];
      2'd1: w_byte = out_data[15:8];
      2'd2: w_byte = out_data[23:16];
      2'd3: w_byte = out_data[31:24];
      default: w_byte = out_data[7:0];
    endcase
    w_half = r_addr[1] ? out_data[31:16] : out_data[15:0];
  end

  always_comb begin
    w_load_data = out_data;
    case (r_f3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {24'h000000, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_data = {16'h0000, w_half};
      default: w_load_data = out_data;
    endcase
  end

  always_comb begin
    w_merged = out_data;
    if (r_f3[1:0] == 2'b00) begin
      case (r_addr[1:0])
        2'd0: w_merged[7:0]   = r_wdata[7:0];
        2'd1: w_merged[15:8]  = r_wdata[7:0];
        2'd2: w_merged[23:16] = r_wdata[7:0];
        2'd3: w_merged[31:24] = r_wdata[7:0];
        default: w_merged = out_data;
      endcase
    end else if (r_f3[1:0] == 2'b01) begin
      if (r_addr[1])
        w_merged[31:16] = r_wdata[15:0];
      else
        w_merged[15:0]  = r_wdata[15:0];
    end
  end

  // In RD/WR the first cycle only raises the strobe; completion is honoured
  // only while the strobe is already high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_f3       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_word     <= '0;
      r_cnt      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      memread    <= 1'b0;
      memwrite   <= 1'b0;
      addr       <= '0;
      wr_data    <= '0;
      data_type  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we      <= req_we;
            r_f3      <= req_funct3;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            req_ready <= 1'b0;
            if (w_req_err) begin
              r_state    <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_we && (req_funct3 == 3'b010)) begin
              r_word  <= req_wdata;
              r_state <= S_WR;
            end else begin
              r_state <= S_RD;
            end
          end
        end

        S_RD: begin
          if (!memread) begin
            memread   <= 1'b1;
            addr      <= {r_addr[31:2], 2'b00};
            data_type <= DT_WORD;
            r_cnt     <= '0;
          end else if (mem_rd_comp) begin
            memread   <= 1'b0;
            addr      <= '0;
            data_type <= '0;
            if (r_we) begin
              r_word  <= w_merged;
              r_state <= S_WR;
            end else begin
              resp_rdata <= w_load_data;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              r_state    <= S_RESP;
            end
          end else if (w_timeout) begin
            memread    <= 1'b0;
            addr       <= '0;
            data_type  <= '0;
            resp_rdata <= '0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_WR: begin
          if (!memwrite) begin
            memwrite  <= 1'b1;
            addr      <= {r_addr[31:2], 2'b00};
            data_type <= DT_WORD;
            wr_data   <= r_word;
            r_cnt     <= '0;
          end else if (mem_wr_comp || w_timeout) begin
            memwrite   <= 1'b0;
            addr       <= '0;
            data_type  <= '0;
            wr_data    <= '0;
            resp_rdata <= '0;
            resp_valid <= 1'b1;
            resp_err   <= !mem_wr_comp;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
          r_state    <= S_IDLE;
        end

        default: begin
          r_state   <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
